// File: rtl/sr_delay_pkg.sv
// Shared constants, stage word type and width helper for the sr_delay_line block.
// Optional ring-rotate feature is enabled by defining SR_DELAY_RECIRC_EN.
package sr_delay_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 16;

  typedef logic [DefWidth-1:0] stage_word_t;

  // $clog2 that never returns 0, so derived port widths stay legal.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sr_stage.sv
// One WIDTH-bit delay stage: async reset, synchronous clear, load enable.
module sr_stage
  import sr_delay_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sr_delay_line.sv
// Multi-channel shift-register delay line with fill tracking and runtime tap select.
// Defining SR_DELAY_RECIRC_EN adds a recirc input that rotates the chain as a ring.
module sr_delay_line
  import sr_delay_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned TAPW = clog2_min1(DEPTH),
  localparam int unsigned CNTW = clog2_min1(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clear,
`ifdef SR_DELAY_RECIRC_EN
  input  logic             recirc,
`endif
  input  logic [WIDTH-1:0] din,
  input  logic [TAPW-1:0]  tap_sel,
  output logic [WIDTH-1:0] dout_tap,
  output logic             tap_valid,
  output logic [WIDTH-1:0] dout_last,
  output logic [CNTW-1:0]  fill,
  output logic             full
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [WIDTH-1:0]            head_d;
  logic                        rotate;
  logic [CNTW-1:0]             fill_d, fill_q;

`ifdef SR_DELAY_RECIRC_EN
  assign rotate = recirc;
`else
  assign rotate = 1'b0;
`endif

  assign head_d = rotate ? stage_q[DEPTH-1] : din;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    if (i == 0) begin : g_head
      assign d_in = head_d;
    end else begin : g_body
      assign d_in = stage_q[i-1];
    end

    sr_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .clear(clear),
      .en   (shift_en),
      .d    (d_in),
      .q    (stage_q[i])
    );
  end

  // A ring rotation moves existing data only, so it does not count as a fill.
  always_comb begin
    fill_d = fill_q;
    if (clear) begin
      fill_d = '0;
    end else if (shift_en && !rotate && (fill_q != CNTW'(DEPTH))) begin
      fill_d = fill_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  always_comb begin
    dout_tap  = '0;
    tap_valid = 1'b0;
    if (32'(tap_sel) < DEPTH) begin
      dout_tap  = stage_q[tap_sel];
      tap_valid = fill_q > CNTW'(tap_sel);
    end
  end

  assign dout_last = stage_q[DEPTH-1];
  assign fill      = fill_q;
  assign full      = (fill_q == CNTW'(DEPTH));

endmodule

// File: tb/tb_sr_delay_line.sv
// Self-checking bench for sr_delay_line: history-queue model plus directed literal checks.
module tb_sr_delay_line;

  localparam int unsigned W    = 8;
  localparam int unsigned D    = 16;
  localparam int unsigned TAPW = 4;
  localparam int unsigned CNTW = 5;

  logic            clk, rst, shift_en, clear, recirc;
  logic [W-1:0]    din;
  logic [TAPW-1:0] tap_sel;
  logic [W-1:0]    dout_tap, dout_last;
  logic            tap_valid, full;
  logic [CNTW-1:0] fill;

  int n_checks = 0;
  int n_fail   = 0;

  sr_delay_line #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clear    (clear),
`ifdef SR_DELAY_RECIRC_EN
    .recirc   (recirc),
`endif
    .din      (din),
    .tap_sel  (tap_sel),
    .dout_tap (dout_tap),
    .tap_valid(tap_valid),
    .dout_last(dout_last),
    .fill     (fill),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: newest word at index 0; positions never written read as zero.
  logic [W-1:0] hist[$];
  int           mfill;

  function automatic logic [W-1:0] exp_stage(input int j);
    if (j < hist.size()) return hist[j];
    return '0;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [W-1:0] nv;
    if (rst) begin
      hist.delete();
      mfill = 0;
    end else if (clear) begin
      hist.delete();
      mfill = 0;
    end else if (shift_en) begin
      nv = recirc ? exp_stage(D - 1) : din;
      hist.push_front(nv);
      if (hist.size() > D) void'(hist.pop_back());
      if (!recirc && mfill < D) mfill++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_dout_last", 32'(dout_last), 32'(exp_stage(D - 1)));
      chk("m_dout_tap", 32'(dout_tap), 32'(exp_stage(int'(tap_sel))));
      chk("m_tap_valid", 32'(tap_valid), 32'(int'(tap_sel) < mfill));
      chk("m_fill", 32'(fill), 32'(mfill));
      chk("m_full", 32'(full), 32'(mfill == D));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic shift(input logic [W-1:0] v);
    shift_en = 1'b1;
    din      = v;
    step();
    shift_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; shift_en = 1'b0; clear = 1'b0; recirc = 1'b0; din = '0; tap_sel = '0;

    // Reset holds everything at zero regardless of inputs.
    for (int i = 0; i < 4; i++) begin
      din      = W'($urandom);
      shift_en = 1'($urandom);
      step();
      chk("rst_dout_last", 32'(dout_last), 32'h0);
      chk("rst_fill", 32'(fill), 32'h0);
      chk("rst_full", 32'(full), 32'h0);
      chk("rst_tap_valid", 32'(tap_valid), 32'h0);
    end
    shift_en = 1'b0;
    rst      = 1'b0;
    step();

    // Fill to saturation.
    for (int i = 1; i <= 16; i++) shift(W'(i));
    chk("fill_dout_last", 32'(dout_last), 32'd1);
    chk("fill_fill", 32'(fill), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    shift(W'(17));
    chk("sat_dout_last", 32'(dout_last), 32'd2);
    chk("sat_fill", 32'(fill), 32'd16);

    // Tap select after three shifts.
    clear = 1'b1; step(); clear = 1'b0;
    shift(8'hA1); shift(8'hB2); shift(8'hC3);
    tap_sel = 4'd0; #1 chk("tap0", 32'(dout_tap), 32'hC3);
    chk("tap0_valid", 32'(tap_valid), 32'd1);
    tap_sel = 4'd1; #1 chk("tap1", 32'(dout_tap), 32'hB2);
    tap_sel = 4'd2; #1 chk("tap2", 32'(dout_tap), 32'hA1);
    chk("tap2_valid", 32'(tap_valid), 32'd1);
    tap_sel = 4'd3; #1 chk("tap3", 32'(dout_tap), 32'h0);
    chk("tap3_valid", 32'(tap_valid), 32'd0);

    // Hold for five disabled edges.
    tap_sel = 4'd2;
    din     = 8'h5A;
    for (int i = 0; i < 5; i++) step();
    chk("hold_tap2", 32'(dout_tap), 32'hA1);
    chk("hold_fill", 32'(fill), 32'd3);

    // Clear beats shift.
    clear = 1'b1; shift_en = 1'b1; din = 8'hFF;
    step();
    clear = 1'b0; shift_en = 1'b0;
    tap_sel = 4'd0; #1;
    chk("clr_tap0", 32'(dout_tap), 32'h0);
    chk("clr_fill", 32'(fill), 32'h0);

    // Sweep taps across a full chain so the per-cycle compare covers every stage.
    for (int i = 0; i < 20; i++) begin
      tap_sel = TAPW'(i);
      shift(W'(8'h30 + i));
    end

    // Async reset mid-stream, between edges, with a shift pending.
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 0; i < 9; i++) shift(W'(8'h40 + i));
    chk("pre_rst_fill", 32'(fill), 32'd9);
    tap_sel  = 4'd0;
    shift_en = 1'b1;
    rst      = 1'b1;
    #1;
    chk("arst_dout_last", 32'(dout_last), 32'h0);
    chk("arst_dout_tap", 32'(dout_tap), 32'h0);
    chk("arst_fill", 32'(fill), 32'h0);
    chk("arst_tap_valid", 32'(tap_valid), 32'h0);
    #1;
    rst      = 1'b0;
    shift_en = 1'b0;
    step();
    chk("post_rst_fill", 32'(fill), 32'h0);

`ifdef SR_DELAY_RECIRC_EN
    for (int i = 0; i < 16; i++) shift(W'(i));
    recirc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      shift(W'(8'hEE));
      chk("rc_fill", 32'(fill), 32'd16);
    end
    recirc = 1'b0;
    chk("rc_dout_last", 32'(dout_last), 32'd0);
    tap_sel = 4'd0; #1 chk("rc_tap0", 32'(dout_tap), 32'd15);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
